rmst_arbiter: RTL and testbench

Shares one AXI read-master command port among `NUM_REQ` prefetch buffers (feature and weight switch buffers). Each buffer issues single-cycle `rmst_req` pulses with a burst address and waits for `rmst_done`. The arbiter latches each pulse, grants the master to one requester at a time, and forwards the master's completion pulse only to the granted requester. It sits between the buffers' `rmst_req`/`addr_offset`/`rmst_done` ports and the single read master.

---
 rtl/rmst_arb_pkg.sv | 13 +
 rtl/rmst_rr_picker.sv | 46 ++++
 rtl/rmst_arbiter.sv | 126 ++++++++++++
 tb/tb_rmst_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmst_arb_pkg.sv
// Shared definitions for the read-master command arbiter: FSM encoding and requester bounds.
package rmst_arb_pkg;

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rmst_rr_picker.sv
// Combinational winner selection over the pending-request vector.
// Round-robin from ptr+1 by default; lowest index wins when RMST_ARB_FIXED_PRIO_EN is defined.
module rmst_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               win_valid_c
);

`ifdef RMST_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Descending scan so the last hit, the lowest index, is the winner.
  always_comb begin
    win_idx_c   = '0;
    win_valid_c = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win_idx_c   = IDX_W'(i);
        win_valid_c = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest after ptr; the nearest pending requester overwrites last.
  always_comb begin
    win_idx_c   = '0;
    win_valid_c = 1'b0;
    cand        = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (pend[cand]) begin
        win_idx_c   = cand;
        win_valid_c = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rmst_arbiter.sv
// Shares one AXI read-master command port among NUM_REQ prefetch buffers.
// Build option: RMST_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module rmst_arbiter
  import rmst_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]            done_o,
  input  logic                          clear,
  output logic                          m_req,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  input  logic                          m_done,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_idx,
  output logic [NUM_REQ-1:0]            overrun
);

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      pend;
  logic [ADDR_WIDTH-1:0]   paddr [NUM_REQ];
  logic                    drop, drop_d;
  logic                    m_req_d, busy_d;
  logic [ADDR_WIDTH-1:0]   m_addr_d;
  logic [IDX_W-1:0]        grant_d;
  logic [NUM_REQ-1:0]      done_d;
  logic [NUM_REQ-1:0]      grant_hit;
  logic [IDX_W-1:0]        win_idx_c;
  logic                    win_valid_c;

  rmst_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .pend        (pend),
    .ptr         (grant_idx),
    .win_idx_c   (win_idx_c),
    .win_valid_c (win_valid_c)
  );

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_req     <= 1'b0;
      m_addr    <= '0;
      grant_idx <= IDX_W'(NUM_REQ - 1);
      done_o    <= '0;
      busy      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req     <= m_req_d;
      m_addr    <= m_addr_d;
      grant_idx <= grant_d;
      done_o    <= done_d;
      busy      <= busy_d;
      drop      <= drop_d;
    end
  end

  // Next state and output decode; a flush in IDLE blocks the grant since pend is being zeroed.
  always_comb begin
    state_d   = state_q;
    m_req_d   = 1'b0;
    m_addr_d  = m_addr;
    grant_d   = grant_idx;
    done_d    = '0;
    drop_d    = drop;
    grant_hit = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid_c && !clear) begin
          state_d              = ST_ISSUE;
          m_req_d              = 1'b1;
          m_addr_d             = paddr[win_idx_c];
          grant_d              = win_idx_c;
          grant_hit[win_idx_c] = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (clear) drop_d = 1'b1;
      end
      ST_WAIT: begin
        if (m_done) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (!drop && !clear) done_d[grant_idx] = 1'b1;
        end else if (clear) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Request capture; a pulse landing on the grant cycle counts as a fresh request, not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_REQ; i++) paddr[i] <= '0;
    end else if (clear) begin
      pend    <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_i[i] && (!pend[i] || grant_hit[i])) begin
          pend[i]  <= 1'b1;
          paddr[i] <= addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
          if (grant_hit[i]) pend[i] <= 1'b0;
          if (req_i[i]) overrun[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rmst_arbiter.sv
// Self-checking bench for rmst_arbiter; expected commands go through a scoreboard queue.
module tb_rmst_arbiter;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned IDX_W      = 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_W-1:0]      idx;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_REQ-1:0]            req_i = '0;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i = '0;
  logic [NUM_REQ-1:0]            done_o;
  logic                          clear = 1'b0;
  logic                          m_req;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic                          m_done = 1'b0;
  logic                          busy;
  logic [IDX_W-1:0]              grant_idx;
  logic [NUM_REQ-1:0]            overrun;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  rmst_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .done_o(done_o),
    .clear(clear), .m_req(m_req), .m_addr(m_addr), .m_done(m_done), .busy(busy),
    .grant_idx(grant_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Every command pulse must match the next expected grant.
  always @(negedge clk) begin
    if (rst_n && m_req === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_m_req: got addr=%h idx=%0d, required no command", m_addr, grant_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (m_addr !== e.addr || grant_idx !== e.idx) begin
          bad++;
          $display("FAIL cmd: got addr=%h idx=%0d, required addr=%h idx=%0d",
                   m_addr, grant_idx, e.addr, e.idx);
        end
      end
    end
  end

  task automatic push_exp(input logic [ADDR_WIDTH-1:0] a, input int idx);
    exp_t e;
    e.addr = a;
    e.idx  = IDX_W'(idx);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_i = '0; clear = 1'b0; m_done = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_req(input logic [NUM_REQ-1:0] mask, input logic [ADDR_WIDTH-1:0] a0,
                           input logic [ADDR_WIDTH-1:0] a1);
    req_i  = mask;
    addr_i = {a1, a0};
    step(1);
    req_i  = '0;
    addr_i = '0;
  endtask

  task automatic pulse_done();
    m_done = 1'b1;
    step(1);
    m_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic wait_mreq(output int n);
    n = 0;
    while (m_req !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req: got %b, required 0", m_req); end
    total++; if (m_addr !== '0) begin bad++; $display("FAIL reset_m_addr: got %h, required 0", m_addr); end
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL reset_done: got %b, required 00", done_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++; if (grant_idx !== 1'b1) begin bad++; $display("FAIL reset_grant_idx: got %0d, required 1", grant_idx); end
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL reset_overrun: got %b, required 00", overrun); end
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    push_exp(64'h1000, 0);
    pulse_req(2'b01, 64'h1000, 64'h0);
    wait_mreq(n);
    total++; if (n !== 1) begin bad++; $display("FAIL single_latency: got %0d, required 1", n); end
    step(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b, required 1", busy); end
    step(6);
    pulse_done();
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL single_done: got %b, required 01", done_o); end
    step(1);
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL single_done_len: got %b, required 00", done_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b, required 0", busy); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL single_sb: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    int n;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      push_exp(64'hA000 + 64'(r), 0);
      push_exp(64'hB000 + 64'(r), 1);
      pulse_req(2'b11, 64'hA000 + 64'(r), 64'hB000 + 64'(r));
      wait_mreq(n);
      total++; if (n !== 1) begin bad++; $display("FAIL cont_lat0: got %0d, required 1", n); end
      step(2);
      pulse_done();
      total++; if (done_o !== 2'b01) begin bad++; $display("FAIL cont_done0: got %b, required 01", done_o); end
      wait_mreq(n);
      total++; if (n !== 1) begin bad++; $display("FAIL cont_lat1: got %0d, required 1", n); end
      step(2);
      pulse_done();
      total++; if (done_o !== 2'b10) begin bad++; $display("FAIL cont_done1: got %b, required 10", done_o); end
      step(1);
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL cont_sb: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] first, second;
    apply_reset();
    push_exp(64'h100, 0);
    pulse_req(2'b01, 64'h100, 64'h0);
    wait_mreq(n);
`ifdef RMST_ARB_FIXED_PRIO_EN
    push_exp(64'h200, 0); push_exp(64'h300, 1); first = 2'b01; second = 2'b10;
`else
    push_exp(64'h300, 1); push_exp(64'h200, 0); first = 2'b10; second = 2'b01;
`endif
    pulse_req(2'b11, 64'h200, 64'h300);
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL rr_no_overrun: got %b, required 00", overrun); end
    step(1);
    pulse_done();
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL rr_done_a: got %b, required 01", done_o); end
    wait_mreq(n);
    total++; if (n !== 1) begin bad++; $display("FAIL rr_lat: got %0d, required 1", n); end
    step(1);
    pulse_done();
    total++; if (done_o !== first) begin bad++; $display("FAIL rr_done_b: got %b, required %b", done_o, first); end
    wait_mreq(n);
    step(1);
    pulse_done();
    total++; if (done_o !== second) begin bad++; $display("FAIL rr_done_c: got %b, required %b", done_o, second); end
    step(1);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rr_sb: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    int n;
    apply_reset();
    push_exp(64'h1000, 0);
    push_exp(64'h2000, 1);
    pulse_req(2'b01, 64'h1000, 64'h0);
    wait_mreq(n);
    pulse_req(2'b10, 64'h0, 64'h2000);
    pulse_req(2'b10, 64'h0, 64'h3000);
    total++; if (overrun !== 2'b10) begin bad++; $display("FAIL overrun_set: got %b, required 10", overrun); end
    pulse_done();
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL overrun_done0: got %b, required 01", done_o); end
    wait_mreq(n);
    step(1);
    pulse_done();
    total++; if (done_o !== 2'b10) begin bad++; $display("FAIL overrun_done1: got %b, required 10", done_o); end
    total++; if (overrun !== 2'b10) begin bad++; $display("FAIL overrun_sticky: got %b, required 10", overrun); end
    pulse_clear();
    total++; if (overrun !== 2'b00) begin bad++; $display("FAIL overrun_clear: got %b, required 00", overrun); end
    step(4);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL overrun_sb: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_clear_mid_burst();
    int n;
    apply_reset();
    push_exp(64'h4000, 0);
    pulse_req(2'b01, 64'h4000, 64'h0);
    wait_mreq(n);
    step(1);
    pulse_req(2'b10, 64'h0, 64'h5000);
    pulse_clear();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy: got %b, required 1", busy); end
    step(2);
    pulse_done();
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL clr_suppress: got %b, required 00", done_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_idle: got %b, required 0", busy); end
    step(6);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_stay_idle: got %b, required 0", busy); end
    push_exp(64'h6000, 0);
    pulse_req(2'b01, 64'h6000, 64'h0);
    wait_mreq(n);
    step(1);
    pulse_done();
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL clr_drop_cleared: got %b, required 01", done_o); end
    step(1);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL clr_sb: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_spurious_done();
    int n;
    apply_reset();
    pulse_done();
    total++; if (done_o !== 2'b00 || busy !== 1'b0) begin bad++;
      $display("FAIL spur_idle: got done=%b busy=%b, required done=00 busy=0", done_o, busy); end
    push_exp(64'h7000, 0);
    pulse_req(2'b01, 64'h7000, 64'h0);
    wait_mreq(n);
    pulse_done();
    total++; if (done_o !== 2'b00 || busy !== 1'b1) begin bad++;
      $display("FAIL spur_issue: got done=%b busy=%b, required done=00 busy=1", done_o, busy); end
    step(2);
    pulse_done();
    total++; if (done_o !== 2'b01) begin bad++; $display("FAIL spur_real_done: got %b, required 01", done_o); end
    step(1);
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    push_exp(64'h8000, 0);
    pulse_req(2'b01, 64'h8000, 64'h0);
    wait_mreq(n);
    step(2);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || m_addr !== '0 || grant_idx !== 1'b1 || m_req !== 1'b0) begin bad++;
      $display("FAIL arst_outputs: got busy=%b addr=%h idx=%0d m_req=%b, required 0/0/1/0",
               busy, m_addr, grant_idx, m_req); end
    step(1);
    rst_n = 1'b1;
    pulse_done();
    total++; if (done_o !== 2'b00 || busy !== 1'b0) begin bad++;
      $display("FAIL arst_done_ignored: got done=%b busy=%b, required 00/0", done_o, busy); end
    step(4);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL arst_sb: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_overrun();
    test_clear_mid_burst();
    test_spurious_done();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
